// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the program counter and runs the imem req/ack
// handshake, presenting pc/instruction pairs to the IF/ID register.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o,
    output logic        fetch_stall_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & 32'hFFFF_FFFC;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [31:0] pc_r;
    logic [31:0] pc_nxt_s;
    logic [31:0] drain_addr_r;
    logic [31:0] drain_addr_nxt_s;
    logic [31:0] ibuf_r;
    logic [31:0] ibuf_nxt_s;
    logic [31:0] target_s;
    logic [31:0] pc_inc_s;

    assign target_s = branch_target_i & 32'hFFFF_FFFC;
    assign pc_inc_s = pc_r + 32'd4;

    // State and datapath registers with asynchronous active-low reset
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r      <= ST_IDLE;
            pc_r         <= RESET_PC_ALIGNED;
            drain_addr_r <= 32'h0000_0000;
            ibuf_r       <= 32'h0000_0000;
        end else begin
            state_r      <= state_nxt_s;
            pc_r         <= pc_nxt_s;
            drain_addr_r <= drain_addr_nxt_s;
            ibuf_r       <= ibuf_nxt_s;
        end
    end

    // Next-state logic; a redirect outranks both stall and handover
    always_comb begin
        state_nxt_s      = state_r;
        pc_nxt_s         = pc_r;
        drain_addr_nxt_s = drain_addr_r;
        ibuf_nxt_s       = ibuf_r;
        case (state_r)
            ST_IDLE: begin
                state_nxt_s = ST_FETCH;
                if (branch_i) begin
                    pc_nxt_s = target_s;
                end else begin
                    pc_nxt_s = pc_r;
                end
            end
            ST_FETCH: begin
                if (branch_i) begin
                    pc_nxt_s = target_s;
                    if (imem_ack_i) begin
                        state_nxt_s = ST_FETCH;
                    end else begin
                        // The in-flight request must finish at its own address
                        drain_addr_nxt_s = pc_r;
                        state_nxt_s      = ST_DRAIN;
                    end
                end else if (imem_ack_i) begin
                    if (stall_i) begin
                        ibuf_nxt_s  = imem_rdata_i;
                        state_nxt_s = ST_HOLD;
                    end else begin
                        pc_nxt_s    = pc_inc_s;
                        state_nxt_s = ST_FETCH;
                    end
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_HOLD: begin
                if (branch_i) begin
                    pc_nxt_s    = target_s;
                    state_nxt_s = ST_FETCH;
                end else if (!stall_i) begin
                    pc_nxt_s    = pc_inc_s;
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            ST_DRAIN: begin
                if (branch_i) begin
                    pc_nxt_s    = target_s;
                    state_nxt_s = ST_DRAIN;
                end else if (imem_ack_i) begin
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                pc_nxt_s    = RESET_PC_ALIGNED;
            end
        endcase
    end

    // Output decode from the current state
    always_comb begin
        imem_req_o    = 1'b0;
        imem_addr_o   = pc_r;
        pc_o          = pc_r;
        instr_o       = 32'h0000_0000;
        fetch_stall_o = 1'b1;
        case (state_r)
            ST_IDLE: begin
                imem_req_o = 1'b0;
            end
            ST_FETCH: begin
                imem_req_o = 1'b1;
                if (imem_ack_i) begin
                    instr_o       = imem_rdata_i;
                    fetch_stall_o = 1'b0;
                end else begin
                    instr_o       = 32'h0000_0000;
                    fetch_stall_o = 1'b1;
                end
            end
            ST_HOLD: begin
                instr_o       = ibuf_r;
                fetch_stall_o = 1'b0;
            end
            ST_DRAIN: begin
                imem_req_o  = 1'b1;
                imem_addr_o = drain_addr_r;
            end
            default: begin
                imem_req_o = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed vector table, hand-written corner
// sequences and randomized traffic against a rule-level reference model.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        stall_i;
    logic        branch_i;
    logic [31:0] branch_target_i;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic [31:0] pc_o;
    logic [31:0] instr_o;
    logic        fetch_stall_o;

    logic        wr_ack;
    logic        wr_req;
    logic [31:0] wr_addr;
    logic [31:0] wr_pc;
    logic [31:0] wr_instr;
    logic        wr_fs;

    always #5 clk = ~clk;

    if_fetch_unit u_dut (
        .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i), .branch_i(branch_i),
        .branch_target_i(branch_target_i), .imem_req_o(imem_req_o),
        .imem_addr_o(imem_addr_o), .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i),
        .pc_o(pc_o), .instr_o(instr_o), .fetch_stall_o(fetch_stall_o)
    );

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk_i(clk), .rst_i(rst_i), .stall_i(1'b0), .branch_i(1'b0),
        .branch_target_i(32'h0000_0000), .imem_req_o(wr_req),
        .imem_addr_o(wr_addr), .imem_ack_i(wr_ack), .imem_rdata_i(32'h1234_5678),
        .pc_o(wr_pc), .instr_o(wr_instr), .fetch_stall_o(wr_fs)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // reference model: what the fetch unit owes the pipeline, in rule terms
    bit          m_started;
    bit          m_drain;
    bit          m_held;
    logic [31:0] m_pc;
    logic [31:0] m_daddr;
    logic [31:0] m_hdata;
    // memory model and handshake history
    int          mcnt;
    int          mlat;
    logic        prev_req;
    logic        prev_ack;
    logic [31:0] prev_addr;
    int          n_handover;

    typedef struct {
        logic        st;
        logic        ack;
        logic [31:0] rd;
        logic        e_req;
        logic [31:0] e_addr;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        e_fs;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    // called at a falling edge; leaves the bench at the falling edge after release
    task automatic do_reset();
        rst_i = 1'b0; stall_i = 1'b0; branch_i = 1'b0; branch_target_i = 32'h0;
        imem_ack_i = 1'b0; imem_rdata_i = 32'h0; wr_ack = 1'b0;
        #1;
        chk("rst_req",   32'(imem_req_o),    32'h0);
        chk("rst_addr",  imem_addr_o,        32'h0);
        chk("rst_pc",    pc_o,               32'h0);
        chk("rst_instr", instr_o,            32'h0);
        chk("rst_stall", 32'(fetch_stall_o), 32'h1);
        m_started = 1'b0; m_drain = 1'b0; m_held = 1'b0;
        m_pc = 32'h0; m_daddr = 32'h0; m_hdata = 32'h0;
        mcnt = 0; mlat = 1; prev_req = 1'b0; prev_ack = 1'b0; prev_addr = 32'h0;
        n_handover = 0;
        @(posedge clk); @(negedge clk);
        rst_i = 1'b1;
    endtask

    // one clock of stimulus; lat = fixed memory latency, 0 = random 1..3
    task automatic cycle(input logic br, input logic st, input logic [31:0] tgt, input int lat);
        logic        ack;
        logic [31:0] rd;
        logic        e_req;
        logic [31:0] e_addr;
        logic [31:0] e_instr;
        logic        e_fs;
        bit          chk_pc;
        logic [31:0] t;
        branch_i = br; stall_i = st; branch_target_i = tgt;
        ack = 1'b0;
        if (imem_req_o === 1'b1) begin
            if (mcnt == 0) mlat = (lat == 0) ? int'($urandom_range(3, 1)) : lat;
            ack = (mcnt >= mlat - 1);
        end
        rd = ack ? mem_word(imem_addr_o) : $urandom;
        imem_ack_i = ack; imem_rdata_i = rd;
        #1;
        e_req = 1'b0; e_addr = m_pc; e_instr = 32'h0; e_fs = 1'b1; chk_pc = 1'b1;
        if (!m_started) begin
            e_req = 1'b0;
        end else if (m_drain) begin
            e_req = 1'b1; e_addr = m_daddr; chk_pc = 1'b0;
        end else if (m_held) begin
            e_instr = m_hdata; e_fs = 1'b0;
        end else begin
            e_req = 1'b1;
            if (ack) begin e_instr = rd; e_fs = 1'b0; end
        end
        if (!br) begin
            chk("req", 32'(imem_req_o), 32'(e_req));
            if (e_req) chk("addr", imem_addr_o, e_addr);
            if (chk_pc) chk("pc", pc_o, m_pc);
            chk("instr", instr_o, e_instr);
            chk("fstall", 32'(fetch_stall_o), 32'(e_fs));
        end
        if (prev_req && !prev_ack && imem_req_o) chk("addr_stable", imem_addr_o, prev_addr);
        if (!br && !st && !fetch_stall_o) n_handover++;
        t = tgt & 32'hFFFF_FFFC;
        if (!m_started) begin
            m_started = 1'b1;
            if (br) m_pc = t;
        end else if (m_drain) begin
            if (br) m_pc = t;
            else if (ack) m_drain = 1'b0;
        end else if (m_held) begin
            if (br) begin m_held = 1'b0; m_pc = t; end
            else if (!st) begin m_held = 1'b0; m_pc = m_pc + 32'd4; end
        end else if (br) begin
            if (!ack) begin m_drain = 1'b1; m_daddr = m_pc; end
            m_pc = t;
        end else if (ack) begin
            if (st) begin m_held = 1'b1; m_hdata = rd; end
            else m_pc = m_pc + 32'd4;
        end
        prev_req = imem_req_o; prev_ack = ack; prev_addr = imem_addr_o;
        if (imem_req_o) mcnt = ack ? 0 : mcnt + 1;
        else mcnt = 0;
        @(posedge clk); @(negedge clk);
    endtask

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 32'h00, 32'h00, 32'h0000_0000, 1'b1};
        tbl[1]  = '{1'b0, 1'b1, 32'h00A0_0093, 1'b1, 32'h00, 32'h00, 32'h00A0_0093, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 32'h0010_0113, 1'b1, 32'h04, 32'h04, 32'h0010_0113, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 32'h0020_81B3, 1'b1, 32'h08, 32'h08, 32'h0020_81B3, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 32'h0000_0413, 1'b1, 32'h0C, 32'h0C, 32'h0000_0413, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 32'h00C0_0513, 1'b1, 32'h10, 32'h10, 32'h00C0_0513, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, 32'h10, 32'h10, 32'h00C0_0513, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, 32'h10, 32'h10, 32'h00C0_0513, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 32'h10, 32'h10, 32'h00C0_0513, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 32'hFFFF_FFFF, 1'b1, 32'h14, 32'h14, 32'h0000_0000, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 32'h0000_0013, 1'b1, 32'h14, 32'h14, 32'h0000_0013, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 1'b1, 32'h18, 32'h18, 32'h0000_0000, 1'b1};

        rst_i = 1'b0; stall_i = 1'b0; branch_i = 1'b0; branch_target_i = 32'h0;
        imem_ack_i = 1'b0; imem_rdata_i = 32'h0; wr_ack = 1'b0;
        @(negedge clk);

        // top-of-memory wrap on the second instance
        do_reset();
        wr_ack = 1'b0;
        #1;
        chk("wrap_idle_req", 32'(wr_req), 32'h0);
        @(posedge clk); @(negedge clk);
        wr_ack = 1'b1;
        #1;
        chk("wrap_req",  32'(wr_req), 32'h1);
        chk("wrap_addr", wr_addr, 32'hFFFF_FFFC);
        chk("wrap_pc",   wr_pc,   32'hFFFF_FFFC);
        @(posedge clk); @(negedge clk);
        wr_ack = 1'b0;
        #1;
        chk("wrap_next_addr", wr_addr, 32'h0000_0000);
        chk("wrap_next_req",  32'(wr_req), 32'h1);
        @(negedge clk);

        // directed vectors: 1-cycle memory, then a stalled handover at 0x10
        do_reset();
        for (int i = 0; i < 12; i++) begin
            stall_i = tbl[i].st; branch_i = 1'b0; branch_target_i = 32'h0;
            imem_ack_i = tbl[i].ack; imem_rdata_i = tbl[i].rd;
            #1;
            chk($sformatf("vec%0d_req", i), 32'(imem_req_o), 32'(tbl[i].e_req));
            if (tbl[i].e_req) chk($sformatf("vec%0d_addr", i), imem_addr_o, tbl[i].e_addr);
            chk($sformatf("vec%0d_pc", i), pc_o, tbl[i].e_pc);
            chk($sformatf("vec%0d_instr", i), instr_o, tbl[i].e_instr);
            chk($sformatf("vec%0d_fstall", i), 32'(fetch_stall_o), 32'(tbl[i].e_fs));
            @(posedge clk); @(negedge clk);
        end

        // 3-cycle memory: one instruction every third cycle
        do_reset();
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 32'h0, 3);
        chk("lat3_handovers", 32'(n_handover), 32'd3);

        // redirect while a request to 0x20 is outstanding
        do_reset();
        cycle(1'b1, 1'b0, 32'h0000_0020, 3);
        cycle(1'b0, 1'b0, 32'h0, 3);
        cycle(1'b1, 1'b0, 32'h0000_0103, 3);
        chk("drain_addr", imem_addr_o, 32'h0000_0020);
        cycle(1'b0, 1'b0, 32'h0, 3);
        chk("redirect_req",  32'(imem_req_o), 32'h1);
        chk("redirect_addr", imem_addr_o, 32'h0000_0100);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 32'h0, 3);

        // reset pulsed with a request outstanding
        do_reset();
        cycle(1'b0, 1'b0, 32'h0, 3);
        cycle(1'b0, 1'b0, 32'h0, 3);
        cycle(1'b0, 1'b0, 32'h0, 3);
        chk("pre_rst_req", 32'(imem_req_o), 32'h1);
        do_reset();
        cycle(1'b0, 1'b0, 32'h0, 1);
        chk("restart_addr", imem_addr_o, 32'h0000_0000);
        cycle(1'b0, 1'b0, 32'h0, 1);
        cycle(1'b0, 1'b0, 32'h0, 1);

        // randomized stall/branch/latency traffic
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom % 10) == 0, ($urandom % 3) == 0, $urandom, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
